// File: rtl/instruction_cache_if.sv
// Fetch-side (PC/busywait) and memory-side (mem_read/mem_busywait) signals
// of the instruction cache. The cache is the slave end.
interface instruction_cache_if #(
    parameter int ADDR_BITS = 10
);
    logic [31:0]          PC;
    logic [31:0]          INSTRUCTION;
    logic                 busywait;
    logic                 mem_read;
    logic [ADDR_BITS-5:0] mem_address;
    logic [127:0]         mem_readdata;
    logic                 mem_busywait;

    modport slave (
        input  PC, mem_readdata, mem_busywait,
        output INSTRUCTION, busywait, mem_read, mem_address
    );

    modport master (
        output PC, mem_readdata, mem_busywait,
        input  INSTRUCTION, busywait, mem_read, mem_address
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with 16-byte blocks. Stalls the
// PC unit with busywait while a missing block is fetched from memory.
module instruction_cache #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input logic                CLK,
    input logic                RESET,
    instruction_cache_if.slave bus
);
    localparam int BLK_BITS = ADDR_BITS - 4;
    localparam int TAG_BITS = BLK_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
    state_t state, state_next;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_store  [LINES];
    logic [127:0]        data_store [LINES];
    logic [BLK_BITS-1:0] fill_addr;

    logic [1:0]            word_sel;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  fill_done;
    logic                  unused_pc;

    assign word_sel   = bus.PC[3:2];
    assign index      = bus.PC[INDEX_BITS+3:4];
    assign tag        = bus.PC[ADDR_BITS-1:INDEX_BITS+4];
    assign fill_index = fill_addr[INDEX_BITS-1:0];
    assign fill_tag   = fill_addr[BLK_BITS-1:INDEX_BITS];
    assign unused_pc  = &{1'b0, bus.PC[31:ADDR_BITS], bus.PC[1:0]};

    assign hit             = valid[index] && (tag_store[index] == tag);
    assign bus.INSTRUCTION = data_store[index][{word_sel, 5'b00000} +: 32];
    assign bus.mem_address = fill_addr;
    assign fill_done       = (state == MEM_READ) && !bus.mem_busywait;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            valid     <= '0;
            fill_addr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && !hit)
                fill_addr <= {tag, index};
            if (fill_done)
                valid[fill_index] <= 1'b1;
        end
    end

    // Block and tag arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (!RESET && fill_done) begin
            data_store[fill_index] <= bus.mem_readdata;
            tag_store[fill_index]  <= fill_tag;
        end
    end

    always_comb begin
        state_next   = state;
        bus.busywait = 1'b0;
        bus.mem_read = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    bus.busywait = 1'b1;
                    state_next   = MEM_READ;
                end
            end
            MEM_READ: begin
                bus.busywait = 1'b1;
                bus.mem_read = 1'b1;
                if (!bus.mem_busywait)
                    state_next = UPDATE;
            end
            UPDATE: begin
                bus.busywait = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset silences both handshakes even when the current PC misses.
        if (RESET) begin
            bus.busywait = 1'b0;
            bus.mem_read = 1'b0;
            state_next   = IDLE;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: stimulus queues expected words, a
// monitor compares them whenever the cache presents an unstalled fetch.
module tb_instruction_cache;
    localparam int LAT = 5;

    logic CLK;
    logic RESET;

    instruction_cache_if #(.ADDR_BITS(10)) bus ();

    instruction_cache #(.ADDR_BITS(10), .INDEX_BITS(3)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    // Memory contents: block 0 holds 0x11111111..0x44444444, block b word k
    // elsewhere is 0xA0000000 | b<<8 | k.
    function automatic logic [31:0] mem_word(input int b, input int k);
        if (b == 0) return 32'h11111111 * (k + 1);
        return 32'hA000_0000 | (32'(b) << 8) | 32'(k);
    endfunction

    int lat_cnt = 0;
    always @(posedge CLK) lat_cnt <= bus.mem_read ? lat_cnt + 1 : 0;

    always_comb begin
        bus.mem_readdata = '0;
        for (int k = 0; k < 4; k++)
            bus.mem_readdata[32*k +: 32] = mem_word(int'(bus.mem_address), k);
        bus.mem_busywait = bus.mem_read && (lat_cnt < LAT - 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every unstalled cycle outside reset is one fetch result.
    always @(negedge CLK) begin
        if (!RESET && !bus.busywait) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_fetch: got %h, required no output", bus.INSTRUCTION);
            end else begin
                check("instruction", bus.INSTRUCTION, exp_q.pop_front());
            end
        end
    end

    // Request tracker: block address at each mem_read rise, and its stability.
    int          rd_cycles = 0;
    logic [5:0]  req_addr  = '0;
    logic        prev_rd   = 1'b0;
    logic        unstable  = 1'b0;
    always @(negedge CLK) begin
        if (bus.mem_read && !prev_rd) req_addr = bus.mem_address;
        if (bus.mem_read && prev_rd && bus.mem_address != req_addr) unstable = 1'b1;
        if (bus.mem_read) rd_cycles++;
        prev_rd = bus.mem_read;
    end

    // Counts stalled cycles until the next unstalled one; returns just after an edge.
    task automatic wait_out(output int stall);
        stall = 0;
        forever begin
            @(negedge CLK);
            if (!bus.busywait) break;
            stall++;
            if (stall > 100) begin
                n_vec++;
                n_fail++;
                $display("FAIL fetch_timeout: got busywait=1 for %0d cycles, required release", stall);
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, output int stall);
        bus.PC = pc;
        exp_q.push_back(exp);
        wait_out(stall);
    endtask

    int st;
    int rd0;

    initial begin
        RESET  = 1'b1;
        bus.PC = 32'h0;
        @(posedge CLK);
        #1;
        repeat (2) begin
            @(negedge CLK);
            check("busywait_in_reset", 32'(bus.busywait), 32'd0);
            check("mem_read_in_reset", 32'(bus.mem_read), 32'd0);
            @(posedge CLK);
            #1;
        end
        RESET = 1'b0;
        #1;
        check("busywait_after_release", 32'(bus.busywait), 32'd1);
        @(posedge CLK);
        #1;
        check("mem_read_after_release", 32'(bus.mem_read), 32'd1);
        check("mem_address_after_release", 32'(bus.mem_address), 32'h00);

        // Abort that request and start a clean cold fill.
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        fetch(32'h000, 32'h11111111, st);
        check("cold_fill_stall", st, 7);
        check("cold_fill_addr", 32'(req_addr), 32'h00);

        rd0 = rd_cycles;
        fetch(32'h004, 32'h22222222, st);
        check("hit_stall_w1", st, 0);
        fetch(32'h008, 32'h33333333, st);
        check("hit_stall_w2", st, 0);
        fetch(32'h00C, 32'h44444444, st);
        check("hit_stall_w3", st, 0);
        check("no_mem_read_on_hits", rd_cycles, rd0);

        // Same index, different tag evicts block 0.
        fetch(32'h080, 32'hA0000800, st);
        check("conflict_stall", st, 7);
        check("conflict_addr", 32'(req_addr), 32'h08);
        fetch(32'h000, 32'h11111111, st);
        check("refill_stall", st, 7);
        check("refill_addr", 32'(req_addr), 32'h00);

        // A different index leaves block 0 resident.
        fetch(32'h010, 32'hA0000100, st);
        check("line1_stall", st, 7);
        check("line1_addr", 32'(req_addr), 32'h01);
        rd0 = rd_cycles;
        fetch(32'h000, 32'h11111111, st);
        check("line0_kept_stall", st, 0);
        fetch(32'h400, 32'h11111111, st);
        check("alias_stall", st, 0);
        check("no_mem_read_line0", rd_cycles, rd0);

        // Reset on the third MEM_READ cycle of a PC=0x020 miss.
        bus.PC = 32'h020;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check("mem_read_before_abort", 32'(bus.mem_read), 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("mem_read_after_abort", 32'(bus.mem_read), 32'd0);
        check("busywait_idle_after_abort", 32'(bus.busywait), 32'd1);
        fetch(32'h000, 32'h11111111, st);
        check("post_reset_miss_stall", st, 7);
        check("post_reset_addr", 32'(req_addr), 32'h00);

        // Latched fill address survives a PC change mid-fill.
        fetch(32'h080, 32'hA0000800, st);
        check("evict_stall", st, 7);
        bus.PC = 32'h000;
        @(posedge CLK);
        #1;
        bus.PC = 32'h0F0;
        repeat (LAT) begin
            @(negedge CLK);
            check("held_mem_read", 32'(bus.mem_read), 32'd1);
            check("held_mem_address", 32'(bus.mem_address), 32'h00);
        end
        @(posedge CLK);
        #1;
        check("update_mem_read", 32'(bus.mem_read), 32'd0);
        check("update_busywait", 32'(bus.busywait), 32'd1);
        exp_q.push_back(32'hA0000F00);
        wait_out(st);
        check("moved_pc_stall", st, 8);
        check("moved_pc_addr", 32'(req_addr), 32'h0F);
        fetch(32'h000, 32'h11111111, st);
        check("latched_fill_hit_stall", st, 0);

        check("mem_address_stable", 32'(unstable), 32'd0);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
